id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode/issue pipeline register sitting directly upstream of the ALU.
- Accepts one fetched MIPS instruction plus its register-file read data, then decodes opcode/funct into the ALU's 12-bit one-hot ALUop and selects the A/B operands.
- Holds the result in a single registered slot, released to the execute stage through a valid/ready handshake with flush support.
- Turns the single-cycle datapath into the first pipelined execute boundary.

Parameters:
- DATA_WIDTH, 32, operand/PC width.
- OP_WIDTH, 12, ALUop width, one-hot.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  32  instruction PC.
- rs_raddr  out  5  combinational, in_inst[25:21].
- rt_raddr  out  5  combinational, in_inst[20:16].
- rs_rdata  in  32  register-file data for rs, valid with in_valid.
- rt_rdata  in  32  register-file data for rt, valid with in_valid.
- flush  in  1  kill the slot and discard any same-cycle input.
- out_valid  out  1  slot holds a valid issued op.
- out_ready  in  1  execute stage accepts.
- out_alu_a  out  32  ALU A operand.
- out_alu_b  out  32  ALU B operand.
- out_aluop  out  12  one-hot: bit0 add, bit1 sub, bit2 and, bit3 or, bit4 nor, bit5 xor, bit6 slt, bit7 sltu, bit8 sll, bit9 srl, bit10 sra, bit11 lui.
- out_wdest  out  5  destination register.
- out_wen  out  1  register write enable.
- out_mem_rd  out  1  lw.
- out_mem_wr  out  1  sw.
- out_store_data  out  32  rt_rdata, for sw.
- out_branch  out  2  01 beq, 10 bne, 00 none.
- out_pc  out  32  registered in_pc.
- out_illegal  out  1  unsupported encoding.

Behaviour:
- Reset (resetn low, asynchronous): every registered output = 0, including out_valid and out_aluop.
- in_ready = !out_valid | out_ready. This is combinational, with no dependence on in_valid.
- Load: when in_valid & in_ready & !flush, capture the decoded payload at the clock edge and set out_valid = 1. Latency is 1 cycle.
- Drain: when out_valid & out_ready & !(load), clear out_valid.
- Stall: while out_valid & !out_ready, all outputs hold stable, bit-exact.
- Flush priority: when flush = 1, out_valid <- 0 next edge regardless of any other input. A same-cycle input handshake completes (in_ready unchanged) but its instruction is dropped.
- Deasserting resetn mid-stall discards the held op.
- R-type (opcode 0), funct mapping:
  - 0x20/0x21 add; 0x22/0x23 sub; 0x24 and; 0x25 or; 0x26 xor; 0x27 nor; 0x2A slt; 0x2B sltu.
  - For these: A = rs_rdata, B = rt_rdata.
  - 0x00/0x02/0x03 sll/srl/sra: A = {27'b0, shamt}, B = rt_rdata.
  - 0x04/0x06/0x07 sllv/srlv/srav: A = rs_rdata, B = rt_rdata.
  - wdest = rd.
- I-type, A = rs_rdata unless noted:
  - 0x08/0x09 add with sign-extended imm.
  - 0x0A slt, sign-extended imm.
  - 0x0B sltu, sign-extended imm.
  - 0x0C and, 0x0D or, 0x0E xor, each with zero-extended imm.
  - 0x0F lui: A = 0, B = {16'b0, imm}.
  - 0x23 lw: add with sign-extended imm, mem_rd = 1.
  - 0x2B sw: add with sign-extended imm, mem_wr = 1, wen = 0.
  - 0x04/0x05 beq/bne: sub with B = rt_rdata, wen = 0, branch set.
  - wdest = rt.
- out_wen = 0 whenever wdest = 0.
- Any other opcode/funct: aluop = 0, wen = 0, mem_rd = mem_wr = 0, branch = 0, illegal = 1. The op still issues with valid = 1 so the exception path sees it.
- Exactly one aluop bit is set for every legal op.
- Back-to-back throughput of 1 op/cycle when out_ready is held high.

Test Plan:
- Reset release, then in_inst = 0x2528FFFF (addiu $8,$9,-1), rs_rdata = 5 -> next cycle: out_valid = 1, A = 0x00000005, B = 0xFFFFFFFF, aluop = 0x001, wdest = 8, wen = 1.
- in_inst = 0x00031100 (sll $2,$3,4), rt_rdata = 0x0000000F -> A = 0x00000004, B = 0x0000000F, aluop = 0x100, wdest = 2.
- 0x34A48000 (ori $4,$5,0x8000) -> B = 0x00008000, aluop = 0x008. Then 0x3C061234 (lui $6,0x1234) -> A = 0, B = 0x00001234, aluop = 0x800, wdest = 6.
- Backpressure: out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, outputs frozen. On out_ready = 1, the next op loads in the same cycle and out_valid stays 1 with no bubble.
- flush = 1 concurrently with an accepted addiu -> next cycle out_valid = 0. Also: in_inst = 0xFC000000 -> illegal = 1, aluop = 0, wen = 0.
- resetn pulsed low mid-stall (asynchronous, not clock-aligned) -> all outputs 0 immediately, and out_valid stays 0 until a new load.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Handshake/payload bundle between fetch+regfile (master side) and the
// decode/issue register feeding the ALU (slave side).
interface id_ex_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 12
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_inst;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [4:0]            rs_raddr;
  logic [4:0]            rt_raddr;
  logic [DATA_WIDTH-1:0] rs_rdata;
  logic [DATA_WIDTH-1:0] rt_rdata;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_alu_a;
  logic [DATA_WIDTH-1:0] out_alu_b;
  logic [OP_WIDTH-1:0]   out_aluop;
  logic [4:0]            out_wdest;
  logic                  out_wen;
  logic                  out_mem_rd;
  logic                  out_mem_wr;
  logic [DATA_WIDTH-1:0] out_store_data;
  logic [1:0]            out_branch;
  logic [DATA_WIDTH-1:0] out_pc;
  logic                  out_illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, rs_rdata, rt_rdata, flush, out_ready,
    output in_ready, rs_raddr, rt_raddr, out_valid, out_alu_a, out_alu_b,
           out_aluop, out_wdest, out_wen, out_mem_rd, out_mem_wr,
           out_store_data, out_branch, out_pc, out_illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, rs_rdata, rt_rdata, flush, out_ready,
    input  in_ready, rs_raddr, rt_raddr, out_valid, out_alu_a, out_alu_b,
           out_aluop, out_wdest, out_wen, out_mem_rd, out_mem_wr,
           out_store_data, out_branch, out_pc, out_illegal
  );
endinterface

// File: rtl/id_ex_stage.sv
// MIPS decode/issue pipeline register: decodes one instruction into a one-hot
// ALUop plus operands and holds it in a single valid/ready slot with flush.
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 12
) (
  input logic         clk,
  input logic         resetn,
  id_ex_stage_if.slave bus
);

  localparam int ADD  = 0;
  localparam int SUB  = 1;
  localparam int AND_ = 2;
  localparam int OR_  = 3;
  localparam int NOR_ = 4;
  localparam int XOR_ = 5;
  localparam int SLT  = 6;
  localparam int SLTU = 7;
  localparam int SLL  = 8;
  localparam int SRL  = 9;
  localparam int SRA  = 10;
  localparam int LUI  = 11;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [OP_WIDTH-1:0]   aluop;
    logic [4:0]            wdest;
    logic                  wen;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [DATA_WIDTH-1:0] store_data;
    logic [1:0]            branch;
    logic [DATA_WIDTH-1:0] pc;
    logic                  illegal;
  } payload_t;

  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [4:0]            rs;
  logic [4:0]            rt;
  logic [4:0]            rd;
  logic [4:0]            shamt;
  logic [15:0]           imm;
  logic [DATA_WIDTH-1:0] simm;
  logic [DATA_WIDTH-1:0] zimm;
  logic [DATA_WIDTH-1:0] shamt_ext;

  payload_t dec;
  payload_t payload_d, payload_q;
  logic     valid_d, valid_q;
  logic     legal;
  logic     no_write;
  logic     load;

  assign {opcode, rs, rt, rd, shamt, funct} = bus.in_inst;
  assign imm       = bus.in_inst[15:0];
  assign simm      = {{(DATA_WIDTH-16){imm[15]}}, imm};
  assign zimm      = {{(DATA_WIDTH-16){1'b0}}, imm};
  assign shamt_ext = {{(DATA_WIDTH-5){1'b0}}, shamt};

  assign bus.rs_raddr = rs;
  assign bus.rt_raddr = rt;

  always_comb begin
    dec            = '0;
    dec.alu_a      = bus.rs_rdata;
    dec.alu_b      = bus.rt_rdata;
    dec.store_data = bus.rt_rdata;
    dec.pc         = bus.in_pc;
    legal          = 1'b1;
    no_write       = 1'b0;
    if (opcode == 6'h00) begin
      dec.wdest = rd;
      case (funct)
        6'h20, 6'h21: dec.aluop[ADD]  = 1'b1;
        6'h22, 6'h23: dec.aluop[SUB]  = 1'b1;
        6'h24:        dec.aluop[AND_] = 1'b1;
        6'h25:        dec.aluop[OR_]  = 1'b1;
        6'h26:        dec.aluop[XOR_] = 1'b1;
        6'h27:        dec.aluop[NOR_] = 1'b1;
        6'h2A:        dec.aluop[SLT]  = 1'b1;
        6'h2B:        dec.aluop[SLTU] = 1'b1;
        6'h00: begin dec.aluop[SLL] = 1'b1; dec.alu_a = shamt_ext; end
        6'h02: begin dec.aluop[SRL] = 1'b1; dec.alu_a = shamt_ext; end
        6'h03: begin dec.aluop[SRA] = 1'b1; dec.alu_a = shamt_ext; end
        6'h04:        dec.aluop[SLL]  = 1'b1;
        6'h06:        dec.aluop[SRL]  = 1'b1;
        6'h07:        dec.aluop[SRA]  = 1'b1;
        default:      legal           = 1'b0;
      endcase
    end else begin
      dec.wdest = rt;
      case (opcode)
        6'h08, 6'h09: begin dec.aluop[ADD]  = 1'b1; dec.alu_b = simm; end
        6'h0A:        begin dec.aluop[SLT]  = 1'b1; dec.alu_b = simm; end
        6'h0B:        begin dec.aluop[SLTU] = 1'b1; dec.alu_b = simm; end
        6'h0C:        begin dec.aluop[AND_] = 1'b1; dec.alu_b = zimm; end
        6'h0D:        begin dec.aluop[OR_]  = 1'b1; dec.alu_b = zimm; end
        6'h0E:        begin dec.aluop[XOR_] = 1'b1; dec.alu_b = zimm; end
        6'h0F: begin
          dec.aluop[LUI] = 1'b1;
          dec.alu_a      = '0;
          dec.alu_b      = zimm;
        end
        6'h23: begin dec.aluop[ADD] = 1'b1; dec.alu_b = simm; dec.mem_rd = 1'b1; end
        6'h2B: begin
          dec.aluop[ADD] = 1'b1;
          dec.alu_b      = simm;
          dec.mem_wr     = 1'b1;
          no_write       = 1'b1;
        end
        6'h04: begin dec.aluop[SUB] = 1'b1; dec.branch = 2'b01; no_write = 1'b1; end
        6'h05: begin dec.aluop[SUB] = 1'b1; dec.branch = 2'b10; no_write = 1'b1; end
        default: legal = 1'b0;
      endcase
    end
    dec.wen = legal & ~no_write & (dec.wdest != 5'd0);
    // Unsupported encodings still issue, stripped of side effects, so the exception path sees them.
    if (!legal) begin
      dec.aluop   = '0;
      dec.wen     = 1'b0;
      dec.mem_rd  = 1'b0;
      dec.mem_wr  = 1'b0;
      dec.branch  = 2'b00;
      dec.illegal = 1'b1;
    end
  end

  assign bus.in_ready = ~valid_q | bus.out_ready;
  assign load         = bus.in_valid & bus.in_ready & ~bus.flush;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d   = 1'b1;
      payload_d = dec;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign bus.out_valid      = valid_q;
  assign bus.out_alu_a      = payload_q.alu_a;
  assign bus.out_alu_b      = payload_q.alu_b;
  assign bus.out_aluop      = payload_q.aluop;
  assign bus.out_wdest      = payload_q.wdest;
  assign bus.out_wen        = payload_q.wen;
  assign bus.out_mem_rd     = payload_q.mem_rd;
  assign bus.out_mem_wr     = payload_q.mem_wr;
  assign bus.out_store_data = payload_q.store_data;
  assign bus.out_branch     = payload_q.branch;
  assign bus.out_pc         = payload_q.pc;
  assign bus.out_illegal    = payload_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: hand-computed expectations queued on each
// accepted instruction and compared while the slot presents them.
module tb_id_ex_stage;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [11:0] op;
    logic [4:0]  wd;
    logic        wen;
    logic        mrd;
    logic        mwr;
    logic [1:0]  br;
    logic        ill;
    logic [31:0] sd;
    logic [31:0] pc;
    bit          skip_ab;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  id_ex_stage_if #(.DATA_WIDTH(32), .OP_WIDTH(12)) bus ();

  id_ex_stage #(.DATA_WIDTH(32), .OP_WIDTH(12)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [11:0] op, input logic [4:0] wd,
                              input logic wen, input logic mrd, input logic mwr,
                              input logic [1:0] br, input logic ill, input bit skip_ab);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.wd = wd; e.wen = wen; e.mrd = mrd; e.mwr = mwr;
    e.br = br; e.ill = ill; e.sd = '0; e.pc = '0; e.skip_ab = skip_ab;
    return e;
  endfunction

  task automatic checkReset();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_a", bus.out_alu_a, 32'd0);
    check("rst_b", bus.out_alu_b, 32'd0);
    check("rst_aluop", 32'(bus.out_aluop), 32'd0);
    check("rst_wdest", 32'(bus.out_wdest), 32'd0);
    check("rst_wen", 32'(bus.out_wen), 32'd0);
    check("rst_memrd", 32'(bus.out_mem_rd), 32'd0);
    check("rst_memwr", 32'(bus.out_mem_wr), 32'd0);
    check("rst_sdata", bus.out_store_data, 32'd0);
    check("rst_branch", 32'(bus.out_branch), 32'd0);
    check("rst_pc", bus.out_pc, 32'd0);
    check("rst_illegal", 32'(bus.out_illegal), 32'd0);
  endtask

  task automatic checkOutput();
    exp_t e;
    check("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      e = sb[0];
      if (!e.skip_ab) begin
        check("alu_a", bus.out_alu_a, e.a);
        check("alu_b", bus.out_alu_b, e.b);
        check("wdest", 32'(bus.out_wdest), 32'(e.wd));
      end
      check("aluop", 32'(bus.out_aluop), 32'(e.op));
      check("wen", 32'(bus.out_wen), 32'(e.wen));
      check("mem_rd", 32'(bus.out_mem_rd), 32'(e.mrd));
      check("mem_wr", 32'(bus.out_mem_wr), 32'(e.mwr));
      check("branch", 32'(bus.out_branch), 32'(e.br));
      check("illegal", 32'(bus.out_illegal), 32'(e.ill));
      check("store_data", bus.out_store_data, e.sd);
      check("pc", bus.out_pc, e.pc);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] pc,
                               input logic [31:0] rsd, input logic [31:0] rtd,
                               input logic v, input logic rdy, input logic fl,
                               input exp_t e);
    logic  exp_ready;
    logic  accept;
    exp_t  ex;
    bus.in_inst   = inst;
    bus.in_pc     = pc;
    bus.rs_rdata  = rsd;
    bus.rt_rdata  = rtd;
    bus.in_valid  = v;
    bus.out_ready = rdy;
    bus.flush     = fl;
    #1;
    exp_ready = (sb.size() == 0) || rdy;
    accept    = v && exp_ready && !fl;
    check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    check("rs_raddr", 32'(bus.rs_raddr), 32'(inst[25:21]));
    check("rt_raddr", 32'(bus.rt_raddr), 32'(inst[20:16]));
    @(posedge clk);
    if (fl) sb.delete();
    else if (sb.size() != 0 && rdy) void'(sb.pop_front());
    if (accept) begin
      ex    = e;
      ex.sd = rtd;
      ex.pc = pc;
      sb.push_back(ex);
    end
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    exp_t none;
    none = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    resetn = 1'b0;
    bus.in_valid = 0; bus.in_inst = 0; bus.in_pc = 0; bus.rs_rdata = 0;
    bus.rt_rdata = 0; bus.flush = 0; bus.out_ready = 0;
    #2;
    checkReset();
    @(negedge clk);
    resetn = 1'b1;

    // Decode coverage, back-to-back with out_ready held high.
    applyStimulus(32'h2528FFFF, 32'h100, 32'd5, 32'h77, 1, 1, 0,
                  mk(32'h5, 32'hFFFFFFFF, 12'h001, 5'd8, 1, 0, 0, 2'b00, 0, 0));
    applyStimulus(32'h00031100, 32'h104, 32'hDEAD, 32'hF, 1, 1, 0,
                  mk(32'h4, 32'hF, 12'h100, 5'd2, 1, 0, 0, 2'b00, 0, 0));
    applyStimulus(32'h34A48000, 32'h108, 32'h12340000, 32'h1, 1, 1, 0,
                  mk(32'h12340000, 32'h8000, 12'h008, 5'd4, 1, 0, 0, 2'b00, 0, 0));
    applyStimulus(32'h3C061234, 32'h10C, 32'h55, 32'h66, 1, 1, 0,
                  mk(32'h0, 32'h1234, 12'h800, 5'd6, 1, 0, 0, 2'b00, 0, 0));
    applyStimulus(32'h8D2A0010, 32'h110, 32'h1000, 32'h9, 1, 1, 0,
                  mk(32'h1000, 32'h10, 12'h001, 5'd10, 1, 1, 0, 2'b00, 0, 0));
    applyStimulus(32'hAD2AFFFC, 32'h114, 32'h2000, 32'hCAFE, 1, 1, 0,
                  mk(32'h2000, 32'hFFFFFFFC, 12'h001, 5'd10, 0, 0, 1, 2'b00, 0, 0));
    applyStimulus(32'h10220003, 32'h118, 32'h7, 32'h8, 1, 1, 0,
                  mk(32'h7, 32'h8, 12'h002, 5'd2, 0, 0, 0, 2'b01, 0, 0));
    applyStimulus(32'h14220003, 32'h11C, 32'h7, 32'h8, 1, 1, 0,
                  mk(32'h7, 32'h8, 12'h002, 5'd2, 0, 0, 0, 2'b10, 0, 0));
    applyStimulus(32'h00221822, 32'h120, 32'h30, 32'h10, 1, 1, 0,
                  mk(32'h30, 32'h10, 12'h002, 5'd3, 1, 0, 0, 2'b00, 0, 0));
    applyStimulus(32'h0022182A, 32'h124, 32'h30, 32'h10, 1, 1, 0,
                  mk(32'h30, 32'h10, 12'h040, 5'd3, 1, 0, 0, 2'b00, 0, 0));
    applyStimulus(32'h00022FC3, 32'h128, 32'hABC, 32'h80000000, 1, 1, 0,
                  mk(32'h1F, 32'h80000000, 12'h400, 5'd5, 1, 0, 0, 2'b00, 0, 0));
    applyStimulus(32'h00220021, 32'h12C, 32'h1, 32'h2, 1, 1, 0,
                  mk(32'h1, 32'h2, 12'h001, 5'd0, 0, 0, 0, 2'b00, 0, 0));
    applyStimulus(32'h30278001, 32'h130, 32'hFFFF, 32'h3, 1, 1, 0,
                  mk(32'hFFFF, 32'h8001, 12'h004, 5'd7, 1, 0, 0, 2'b00, 0, 0));
    applyStimulus(32'h2C27FFFF, 32'h134, 32'h4, 32'h3, 1, 1, 0,
                  mk(32'h4, 32'hFFFFFFFF, 12'h080, 5'd7, 1, 0, 0, 2'b00, 0, 0));

    // Backpressure: three stalled cycles, then the waiting op loads with no bubble.
    for (int i = 0; i < 3; i++)
      applyStimulus(32'h00221822, 32'h138, 32'h99, 32'h11, 1, 0, 0,
                    mk(32'h99, 32'h11, 12'h002, 5'd3, 1, 0, 0, 2'b00, 0, 0));
    applyStimulus(32'h00221822, 32'h138, 32'h99, 32'h11, 1, 1, 0,
                  mk(32'h99, 32'h11, 12'h002, 5'd3, 1, 0, 0, 2'b00, 0, 0));

    // Flush alongside an accepted addiu kills both the slot and the input.
    applyStimulus(32'h2528FFFF, 32'h13C, 32'd5, 32'h0, 1, 1, 1, none);
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 0, none);

    // Unsupported encodings still issue, with no side effects.
    applyStimulus(32'hFC000000, 32'h140, 32'h1, 32'h2, 1, 1, 0,
                  mk(0, 0, 12'h000, 5'd0, 0, 0, 0, 2'b00, 1, 1));
    applyStimulus(32'h00221801, 32'h144, 32'h1, 32'h2, 1, 1, 0,
                  mk(0, 0, 12'h000, 5'd0, 0, 0, 0, 2'b00, 1, 1));

    // Asynchronous reset in the middle of a stall.
    applyStimulus(32'h00221822, 32'h148, 32'h44, 32'h22, 1, 1, 0,
                  mk(32'h44, 32'h22, 12'h002, 5'd3, 1, 0, 0, 2'b00, 0, 0));
    applyStimulus(32'h00221822, 32'h14C, 32'h44, 32'h22, 1, 0, 0, none);
    #3 resetn = 1'b0;
    #1 checkReset();
    sb.delete();
    #3 resetn = 1'b1;
    @(negedge clk);
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, none);
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 0, none);
    applyStimulus(32'h3C061234, 32'h150, 32'h0, 32'h0, 1, 1, 0,
                  mk(32'h0, 32'h1234, 12'h800, 5'd6, 1, 0, 0, 2'b00, 0, 0));
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 0, none);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
